jesd_tx_link_ctrl: RTL

- JESD204B single-lane transmit link-layer sequencer that drives the 8b/10b encoder's character input.
- Generates Code Group Synchronisation (CGS) commas, then the Initial Lane Alignment Sequence (ILAS), then user data, all on the local multiframe clock (LMFC) grid.
- Reacts to the receiver's SYNC~ request.
- Sits between the transport layer (octet source) and the running-disparity encoder ROMs; one octet per clock.

---
 rtl/jesd_tx_link_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/jesd_tx_link_ctrl.sv
// JESD204B single-lane transmit link-layer sequencer: CGS, ILAS and user data
// on the LMFC grid, feeding an 8b/10b encoder one character per clock.
// Optional: define JESD_CHAR_REPLACE_EN for frame/multiframe-end character
// replacement (K28.7 / K28.3) when scrambling is disabled.
module jesd_tx_link_ctrl #(
    parameter int unsigned F         = 2,
    parameter int unsigned K         = 16,
    parameter int unsigned ILAS_MF   = 4,
    parameter int unsigned SYNC_FILT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_sync_n,
    input  logic [111:0] i_cfg,
    input  logic [7:0]   i_tx_data,
    input  logic         i_tx_valid,
    output logic         o_data_rdy,
    output logic [7:0]   o_char,
    output logic         o_k,
    output logic         o_rd_en,
    output logic         o_lmfc,
    output logic [1:0]   o_state,
    output logic         o_underflow
);

    localparam int unsigned OctPerMf = F * K;
    localparam logic [7:0]  OctLast  = 8'(OctPerMf - 1);
    localparam int unsigned MfW      = 3;
    localparam logic [MfW-1:0] MfLast = MfW'(ILAS_MF - 1);
    localparam int unsigned SyncW    = $clog2(SYNC_FILT + 1);
    localparam logic [SyncW-1:0] SyncLast = SyncW'(SYNC_FILT - 1);

    localparam logic [7:0] K28_0 = 8'h1C;
    localparam logic [7:0] K28_3 = 8'h7C;
    localparam logic [7:0] K28_4 = 8'h9C;
    localparam logic [7:0] K28_5 = 8'hBC;

    typedef enum logic [1:0] {
        StCgs      = 2'd0,
        StWaitLmfc = 2'd1,
        StIlas     = 2'd2,
        StData     = 2'd3
    } state_e;

    state_e           state_q;
    logic [7:0]       oct_q;
    logic [MfW-1:0]   mf_q;
    logic [SyncW-1:0] sync_cnt_q;
    logic [7:0]       char_q;
    logic             k_q;
    logic             rd_en_q;
    logic             lmfc_q;
    logic             underflow_q;

    logic [7:0] ilas_char;
    logic       ilas_k;
    logic [3:0] cfg_idx;
    logic [7:0] data_raw;
    logic [7:0] data_char;
    logic       data_k;

    // ILAS character for the current octet position and multiframe.
    always_comb begin
        ilas_char = oct_q;
        ilas_k    = 1'b0;
        cfg_idx   = oct_q[3:0] - 4'd2;
        if (oct_q == 8'd0) begin
            ilas_char = K28_0;
            ilas_k    = 1'b1;
        end else if (oct_q == OctLast) begin
            ilas_char = K28_3;
            ilas_k    = 1'b1;
        end else if (mf_q == MfW'(1)) begin
            if (oct_q == 8'd1) begin
                ilas_char = K28_4;
                ilas_k    = 1'b1;
            end else if (oct_q < 8'd16) begin
                ilas_char = i_cfg[{cfg_idx, 3'b000} +: 8];
            end
        end
    end

    assign data_raw = i_tx_valid ? i_tx_data : 8'h00;

`ifdef JESD_CHAR_REPLACE_EN
    localparam logic [2:0] FposLast = 3'(F - 1);
    localparam logic [7:0] K28_7    = 8'hFC;

    logic [2:0] fpos_q;
    logic [7:0] last_q;
    logic       hist_vld_q;

    // Frame-end replacement; comparison uses the unreplaced octet history.
    always_comb begin
        data_char = data_raw;
        data_k    = 1'b0;
        if (fpos_q == FposLast && hist_vld_q && data_raw == last_q) begin
            data_char = (oct_q == OctLast) ? K28_3 : K28_7;
            data_k    = 1'b1;
        end
    end

    // Frame position tracks the octet counter; history reloads on DATA entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpos_q     <= 3'd0;
            last_q     <= 8'h00;
            hist_vld_q <= 1'b0;
        end else begin
            fpos_q <= (fpos_q == FposLast || oct_q == OctLast) ? 3'd0 : fpos_q + 3'd1;
            if (state_q == StIlas && oct_q == OctLast && mf_q == MfLast) begin
                last_q     <= 8'h00;
                hist_vld_q <= 1'b0;
            end else if (state_q == StData && fpos_q == FposLast) begin
                last_q     <= data_raw;
                hist_vld_q <= 1'b1;
            end
        end
    end
`else
    // Data passes through unmodified.
    always_comb begin
        data_char = data_raw;
        data_k    = 1'b0;
    end
`endif

    // Link FSM, free-running LMFC octet counter and registered encoder outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StCgs;
            oct_q       <= 8'd0;
            mf_q        <= '0;
            sync_cnt_q  <= '0;
            char_q      <= K28_5;
            k_q         <= 1'b1;
            rd_en_q     <= 1'b0;
            lmfc_q      <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            oct_q       <= (oct_q == OctLast) ? 8'd0 : oct_q + 8'd1;
            rd_en_q     <= 1'b1;
            lmfc_q      <= (oct_q == 8'd0);
            underflow_q <= 1'b0;
            unique case (state_q)
                StCgs: begin
                    char_q <= K28_5;
                    k_q    <= 1'b1;
                    if (i_sync_n) state_q <= StWaitLmfc;
                end
                StWaitLmfc: begin
                    char_q <= K28_5;
                    k_q    <= 1'b1;
                    // A renewed sync request wins over the LMFC boundary.
                    if (!i_sync_n) begin
                        state_q <= StCgs;
                    end else if (oct_q == OctLast) begin
                        state_q <= StIlas;
                        mf_q    <= '0;
                    end
                end
                StIlas: begin
                    char_q <= ilas_char;
                    k_q    <= ilas_k;
                    if (oct_q == OctLast) begin
                        if (mf_q == MfLast) begin
                            state_q    <= StData;
                            sync_cnt_q <= '0;
                        end else begin
                            mf_q <= mf_q + MfW'(1);
                        end
                    end
                end
                StData: begin
                    char_q      <= data_char;
                    k_q         <= data_k;
                    underflow_q <= !i_tx_valid;
                    if (!i_sync_n) begin
                        if (sync_cnt_q == SyncLast) begin
                            state_q    <= StCgs;
                            sync_cnt_q <= '0;
                        end else begin
                            sync_cnt_q <= sync_cnt_q + SyncW'(1);
                        end
                    end else begin
                        sync_cnt_q <= '0;
                    end
                end
                default: state_q <= StCgs;
            endcase
        end
    end

    assign o_char      = char_q;
    assign o_k         = k_q;
    assign o_rd_en     = rd_en_q;
    assign o_lmfc      = lmfc_q;
    assign o_underflow = underflow_q;
    assign o_state     = state_q;
    assign o_data_rdy  = (state_q == StData);

endmodule
